// File: rtl/motor_pwm_ctrl_if.sv
// Command bus from the remote decoder into the motor PWM controller.
interface motor_pwm_ctrl_if #(
  parameter int DUTY_W = 4
);
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [DUTY_W-1:0] speed;

  modport master (output cmd_valid, cmd, speed);
  modport slave  (input  cmd_valid, cmd, speed);
endinterface

// File: rtl/motor_pwm_ctrl.sv
// Two-motor PWM/direction controller with soft-start ramping, reversal dead
// time and a command watchdog; all motion advances on ticks derived from clk_dec.

module motor_pwm_side #(
  parameter int DUTY_W     = 4,
  parameter int DEAD_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              boundary,
  input  logic [DUTY_W-1:0] step,
  input  logic              tgt_dir,
  input  logic [DUTY_W-1:0] tgt_duty,
  output logic              pwm,
  output logic              dir,
  output logic              busy
);
  localparam int DEAD_W = (DEAD_TICKS < 1) ? 1 : $clog2(DEAD_TICKS + 1);

  typedef enum logic {S_RUN, S_DEAD} state_e;

  state_e            state, state_n;
  logic [DUTY_W-1:0] duty, duty_n;
  logic              dir_q, dir_n;
  logic [DEAD_W-1:0] dead_cnt, dead_n;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= S_RUN;
      duty     <= '0;
      dir_q    <= 1'b1;
      dead_cnt <= '0;
      pwm      <= 1'b0;
    end else begin
      state    <= state_n;
      duty     <= duty_n;
      dir_q    <= dir_n;
      dead_cnt <= dead_n;
      pwm      <= (state == S_RUN) && (step < duty);
    end
  end

  // Ramp decisions happen once per PWM period; the dead counter runs per tick.
  // A direction change is only allowed after the duty has ramped to zero.
  always_comb begin
    state_n = state;
    duty_n  = duty;
    dir_n   = dir_q;
    dead_n  = dead_cnt;
    case (state)
      S_RUN: if (boundary) begin
        if (tgt_dir == dir_q) begin
          if (duty < tgt_duty)      duty_n = duty + 1'b1;
          else if (duty > tgt_duty) duty_n = duty - 1'b1;
        end else if (duty != '0) begin
          duty_n = duty - 1'b1;
        end else begin
          state_n = S_DEAD;
          dead_n  = DEAD_W'(DEAD_TICKS);
        end
      end
      S_DEAD: if (tick) begin
        if (dead_cnt <= DEAD_W'(1)) begin
          state_n = S_RUN;
          dir_n   = tgt_dir;
          dead_n  = '0;
        end else begin
          dead_n = dead_cnt - 1'b1;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  assign dir  = dir_q;
  assign busy = (state == S_DEAD) || (duty != tgt_duty);
endmodule

module motor_pwm_ctrl #(
  parameter int DUTY_W     = 4,
  parameter int DEAD_TICKS = 4,
  parameter int WDOG_TICKS = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_dec,
  motor_pwm_ctrl_if.slave  cmd_if,
  output logic             pwm_l,
  output logic             pwm_r,
  output logic             dir_l,
  output logic             dir_r,
  output logic             busy
);
  localparam int NUM_SIDES = 2;
  localparam int WDOG_W    = $clog2(WDOG_TICKS + 1);
  localparam logic [DUTY_W-1:0] STEP_MAX = '1;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BACK  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } cmd_e;

  // [1:0] synchronise clk_dec, [2] holds the previous value for edge detect
  logic [2:0]        sync_pipe;
  logic              tick, boundary;
  logic [DUTY_W-1:0] step;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_hit;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[1:0], clk_dec};
  end

  assign tick     = sync_pipe[1] & ~sync_pipe[2];
  assign boundary = tick && (step == STEP_MAX);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)     step <= '0;
    else if (tick) step <= step + 1'b1;
  end

  assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_TICKS));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                     wdog_cnt <= '0;
    else if (cmd_if.cmd_valid)     wdog_cnt <= '0;
    else if (tick && !wdog_hit)    wdog_cnt <= wdog_cnt + 1'b1;
  end

  // Index 0 is the left motor, index 1 the right; dir bit 1 = forward.
  logic [NUM_SIDES-1:0]             tgt_dir;
  logic [NUM_SIDES-1:0][DUTY_W-1:0] tgt_duty;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tgt_dir  <= '1;
      tgt_duty <= '0;
    end else if (cmd_if.cmd_valid) begin
      case (cmd_e'(cmd_if.cmd))
        CMD_STOP:  tgt_duty <= '0;
        CMD_FWD:   begin tgt_dir <= 2'b11; tgt_duty <= {NUM_SIDES{cmd_if.speed}}; end
        CMD_BACK:  begin tgt_dir <= 2'b00; tgt_duty <= {NUM_SIDES{cmd_if.speed}}; end
        CMD_LEFT:  begin tgt_dir <= 2'b10; tgt_duty <= {NUM_SIDES{cmd_if.speed}}; end
        CMD_RIGHT: begin tgt_dir <= 2'b01; tgt_duty <= {NUM_SIDES{cmd_if.speed}}; end
        default:   ;
      endcase
    end else if (wdog_hit) begin
      tgt_duty <= '0;
    end
  end

  logic [NUM_SIDES-1:0] pwm_v, dir_v, busy_v;

  for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
    motor_pwm_side #(
      .DUTY_W     (DUTY_W),
      .DEAD_TICKS (DEAD_TICKS)
    ) u_side (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .boundary (boundary),
      .step     (step),
      .tgt_dir  (tgt_dir[s]),
      .tgt_duty (tgt_duty[s]),
      .pwm      (pwm_v[s]),
      .dir      (dir_v[s]),
      .busy     (busy_v[s])
    );
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) busy <= 1'b0;
    else       busy <= |busy_v;
  end

  assign pwm_l = pwm_v[0];
  assign pwm_r = pwm_v[1];
  assign dir_l = dir_v[0];
  assign dir_r = dir_v[1];
endmodule

// File: doc/motor_pwm_ctrl.md
Name: motor_pwm_ctrl

Overview:
- Consumes the divided clock `clk_dec` from the frequency divider and decoded remote commands.
- Drives PWM and direction pins for the left and right motors through the H-bridge.
- Provides soft-start ramping, dead time on direction reversal, and a command watchdog that stops the car when remote commands stop arriving.
- Sits between the command decoder and the motor driver pins.

Parameters:
- DUTY_W, 4: duty resolution in bits. PWM period = 2**DUTY_W ticks.
- DEAD_TICKS, 4: ticks both outputs of a side are held off before that side's direction flips.
- WDOG_TICKS, 500: ticks without `cmd_valid` before the target is forced to STOP.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high (asserted when 1).
- clk_dec  in  1  divided clock from freq_div; asynchronous to internal tick logic, synchronised internally.
- cmd_valid  in  1  single-cycle strobe qualifying `cmd` and `speed`.
- cmd  in  3  0=STOP, 1=FWD, 2=BACK, 3=LEFT, 4=RIGHT; 5..7 reserved.
- speed  in  DUTY_W  target duty, 0..2**DUTY_W-1.
- pwm_l  out  1  left motor PWM.
- pwm_r  out  1  right motor PWM.
- dir_l  out  1  left direction, 1=forward.
- dir_r  out  1  right direction, 1=forward.
- busy  out  1  high while either side is in DEAD or has duty != target duty.

Behaviour:
- **Reset.** While `rst_n`=1, all registers clear asynchronously:
  - `pwm_l`/`pwm_r`/`busy` = 0, `dir_l`/`dir_r` = 1.
  - Duties 0, targets STOP, both sides in RUN.
  - Step counter, dead counters, watchdog and synchroniser all 0.
  - Reset mid-motion drops PWM low immediately.
- **Tick generation.**
  - `clk_dec` passes through two flops, then an edge register.
  - `tick` is a one-`clk` pulse on each 0->1 of the synchronised signal.
  - `tick` fires 3 `clk` cycles after the `clk_dec` rising edge.
  - All behaviour below advances only on `tick`, except command capture.
- **Command capture.**
  - On `cmd_valid`, latch per-side target (dir, duty), each side's duty = `speed`:
    - FWD: both forward.
    - BACK: both reverse.
    - LEFT: left reverse, right forward.
    - RIGHT: left forward, right reverse.
    - STOP: duty 0, direction unchanged.
  - On `cmd_valid` with cmd 5..7: targets unchanged, watchdog still cleared.
  - New targets take effect from the next cycle.
- **Watchdog.**
  - Counter increments on `tick` and clears on `cmd_valid`. `cmd_valid` wins if it coincides with `tick`.
  - Reaching WDOG_TICKS forces both targets to STOP duty 0 and saturates the counter there.
- **PWM.**
  - Shared step counter 0..2**DUTY_W-1, +1 per tick, wraps.
  - pwm_x = (step < duty_x), registered.
  - duty 0 gives constant low; max duty gives high for 15 of 16 steps.
- **Per-side FSM, RUN/DEAD.** Evaluated only on period boundary (`tick` with step==max), except DEAD counting.
  - RUN, target dir == dir_x: duty steps ±1 toward target duty, or holds if equal.
  - RUN, target dir != dir_x, duty>0: duty -1 per period.
  - RUN, target dir != dir_x, duty==0: go to DEAD, load dead counter = DEAD_TICKS.
  - DEAD: pwm_x=0. Counter decrements per tick. At 0: dir_x <= target dir, back to RUN, ramp-up starts at next boundary.
  - Target changes while in DEAD: dir is sampled at exit, and DEAD completes regardless. If the target reverts to the original dir, dir_x is unchanged.
- **busy.** Combinational OR of both sides' DEAD state or duty != target duty, then registered.

Test Plan:
- **Reset values.** Assert `rst_n` mid-PWM with duty 8 -> same cycle `pwm_l`=`pwm_r`=0, `dir`=1, `busy`=0. After release, outputs stay idle with no command.
- **Soft start.** FWD speed 4 -> duty rises 1,2,3,4 at successive 16-tick boundaries; `busy` drops after duty 4. Steady state: `pwm` high exactly 4 ticks of every 16.
- **Reversal.** From FWD duty 3, send BACK speed 2 -> duty steps 2,1,0, then DEAD 4 ticks with pwm low. Then `dir`=0 and duty ramps to 1, then 2; no cycle ever has `pwm` high while `dir` changes.
- **Turn.** LEFT speed 5 from STOP -> `dir_l`=0, `dir_r`=1. Both sides pass through DEAD only where a dir change is needed: left yes, right no.
- **Watchdog.** With WDOG_TICKS=20, FWD speed 6 and no further `cmd_valid` -> after the 20th tick the target becomes 0 and duty ramps down to 0. A `cmd_valid` on the same cycle as the 20th tick prevents the stop.
- **Reserved/simultaneous.** cmd=6 during motion -> targets unchanged, watchdog cleared. `cmd_valid` coincident with a period-boundary `tick` -> that boundary uses the old target; the new target applies at the next boundary.
